mem_pattern_tester: RTL
=======================

// Module: mem_pattern_tester
// PURPOSE
//  Parametrised self-checking memory test engine on the SRAM-like wrapper bus (addr/cs/byte-en/we/wr/rd/ready/busy)
//  of sdram_ddr_wrapper. Sits in the ui_clk domain between top level and wrapper; replaces ad-hoc test FSMs.
//  Write-then-read-back per address, selectable pattern, address window, stride, pass count; error/first-fail capture.
// PARAMETERS
//  DATA_W     16       wrapper data width; multiple of 8
//  ADDR_W     29       word-address width
//  STRIDE     50       address increment per step (>=1)
//  ERR_W      16       error counter width (saturating)
//  PASS_W     8        pass counter / pass limit width
//  TIMEOUT    4096     max cycles waiting for i_mem_ready before abort
// PORTS
//  i_clk             in   1         clock (wrapper ui_clk)
//  i_rst_n           in   1         reset, asynchronous, active-low
//  i_start           in   1         pulse: begin test from IDLE/DONE
//  i_stop            in   1         pulse: stop after current transaction completes
//  i_mode            in   2         0 addr, 1 ~addr, 2 checkerboard, 3 walking-one
//  i_addr_lo         in   ADDR_W    first address (inclusive)
//  i_addr_hi         in   ADDR_W    last address bound (inclusive)
//  i_passes          in   PASS_W    passes to run; 0 = run until i_stop
//  o_mem_addr        out  32        wrapper address, {zero-pad, addr}
//  o_mem_cs          out  1         chip select
//  o_mem_be          out  DATA_W/8  byte enables (all ones while requesting)
//  o_mem_we          out  1         1 write, 0 read
//  o_mem_wr          out  DATA_W    write data
//  i_mem_rd          in   DATA_W    read data, valid with i_mem_ready
//  i_mem_ready       in   1         one-cycle transaction-complete pulse
//  i_mem_busy        in   1         wrapper busy
//  o_running         out  1         FSM not in IDLE/DONE
//  o_done            out  1         in DONE (pass limit, stop, or timeout)
//  o_timeout         out  1         sticky: ready never arrived within TIMEOUT
//  o_err_flag        out  1         sticky: at least one mismatch this run
//  o_err_cnt         out  ERR_W     mismatches, saturates at all-ones
//  o_pass_cnt        out  PASS_W    completed passes
//  o_fail_addr/_exp/_got out ADDR_W/DATA_W/DATA_W  first mismatch capture
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; flip=0; cur=0.
//  States: IDLE, ARM, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
//  IDLE/DONE --i_start--> ARM: clear err/pass/timeout/capture, cur<=i_addr_lo, flip<=0. i_start ignored elsewhere.
//  ARM: wait i_mem_busy==0 -> WR_REQ.
//  *_REQ: drive cs=1, be=all-ones, addr=cur, we (1 WR / 0 RD), wr=pattern^{DATA_W{flip}}; hold until busy seen
//   (REQ->WAIT on first busy=1 cycle); request outputs go to 0 the cycle after busy observed.
//  *_WAIT: on i_mem_ready: WR_WAIT->RD_REQ; RD_WAIT compares i_mem_rd to expected in that same cycle.
//   Mismatch: err_cnt+1 (saturating), err_flag<=1; capture fail_* only if err_flag was 0 (first only).
//  Advance after read: next=cur+STRIDE computed at ADDR_W+1 bits; if next>i_addr_hi or carry -> cur<=i_addr_lo,
//   pass_cnt+1, flip<=~flip; if i_passes!=0 and pass_cnt+1==i_passes -> DONE; else -> WR_REQ.
//  Patterns (index = cur): 0 cur[DATA_W-1:0] (zero-ext), 1 inverse, 2 cur[0]?0xAA..:0x55.., 3 1<<(cur mod DATA_W).
//  i_stop: latched; acted on at next ready in *_WAIT (after that txn's check) -> DONE; never abandons a txn.
//  Watchdog: counter cleared on entering *_REQ; in REQ/WAIT, TIMEOUT cycles without progress -> o_timeout=1,
//   request deasserted, DONE.
//  Simultaneous i_stop and pass-limit on same ready: DONE once, pass counted. i_addr_lo>i_addr_hi: one addr/pass.
//  Async reset mid-transaction: outputs drop immediately; wrapper must be reset together (shared reset).
//  Window/mode/passes sampled live; must be held stable while o_running.
// STRUCTURE
//  Package mem_test_pkg: state encoding, MODE_* constants, pattern function prototype widths.
//  Sub-module mem_test_pattern_gen (combinational: mode, addr, flip -> DATA_W pattern), used for write and expect.
//  Top FSM, watchdog and counters stay in mem_pattern_tester; no memories inferred.
// TESTING (bench: behavioural wrapper model, 1-8 cycle ready latency, 64-word array)
//  mode0, lo=0, hi=199, STRIDE=50, passes=2 -> 8 writes/8 reads at 0,50,100,150; pass_cnt=2, done, err_cnt=0.
//  model corrupts bit3 of read at addr 100 on pass 1 -> err_cnt=1, fail_addr=100, fail_exp=0x0064, fail_got=0x006C.
//  corrupt every read, ERR_W=4, passes=5 -> err_cnt saturates at 15; fail_* hold first mismatch only.
//  mode3, passes=0, i_stop during WR_WAIT at addr 50 -> read of 50 completes and is checked, then DONE; no cs after.
//  model never pulses ready, TIMEOUT=64 -> o_timeout=1, done within 64+3 cycles, cs low.
//  assert i_rst_n low in RD_WAIT -> all outputs 0 same cycle; restart after release runs clean.

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared encodings for the memory pattern tester: FSM state codes, pattern modes,
// and the checkerboard byte helper used by the pattern generator.
package mem_test_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_WR_REQ  = 3'd2;
  localparam logic [2:0] ST_WR_WAIT = 3'd3;
  localparam logic [2:0] ST_RD_REQ  = 3'd4;
  localparam logic [2:0] ST_RD_WAIT = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef enum logic [1:0] {
    MODE_ADDR    = 2'd0,
    MODE_INV     = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_WALK1   = 2'd3
  } mode_e;

  function automatic logic [7:0] checker_byte(input logic odd);
    return odd ? 8'hAA : 8'h55;
  endfunction

endpackage

// File: rtl/mem_test_pattern_gen.sv
// Combinational data pattern for a given mode/address; flip inverts every bit so
// alternate passes exercise both polarities of each cell.
module mem_test_pattern_gen
  import mem_test_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 29
) (
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flip,
  output logic [DATA_W-1:0] pattern
);

  logic [ADDR_W+DATA_W-1:0] addr_ext;
  logic [ADDR_W-1:0]        bit_idx;
  logic [DATA_W-1:0]        base;

  // widening first keeps the low-slice legal even when ADDR_W < DATA_W
  assign addr_ext = {{DATA_W{1'b0}}, addr};
  assign bit_idx  = addr % ADDR_W'(DATA_W);

  always_comb begin
    base = '0;
    case (mode_e'(mode))
      MODE_ADDR:    base = addr_ext[DATA_W-1:0];
      MODE_INV:     base = ~addr_ext[DATA_W-1:0];
      MODE_CHECKER: base = {(DATA_W/8){checker_byte(addr[0])}};
      MODE_WALK1:   base = DATA_W'(1) << bit_idx;
      default:      base = '0;
    endcase
    pattern = base ^ {DATA_W{flip}};
  end

endmodule

// File: rtl/mem_pattern_tester.sv
// Write-then-read-back memory test engine driving the SRAM-like wrapper bus,
// with watchdog abort, saturating error count and first-failure capture.
//
// state    | meaning
// IDLE     | after reset, waiting for start
// ARM      | run set up, waiting for wrapper idle
// WR_REQ   | write request held until busy seen
// WR_WAIT  | write accepted, waiting for ready
// RD_REQ   | read request held until busy seen
// RD_WAIT  | read accepted, check data on ready and advance
// DONE     | finished (pass limit, stop or timeout)
module mem_pattern_tester
  import mem_test_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 29,
  parameter int STRIDE  = 50,
  parameter int ERR_W   = 16,
  parameter int PASS_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [1:0]          i_mode,
  input  logic [ADDR_W-1:0]   i_addr_lo,
  input  logic [ADDR_W-1:0]   i_addr_hi,
  input  logic [PASS_W-1:0]   i_passes,
  output logic [31:0]         o_mem_addr,
  output logic                o_mem_cs,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic                o_mem_we,
  output logic [DATA_W-1:0]   o_mem_wr,
  input  logic [DATA_W-1:0]   i_mem_rd,
  input  logic                i_mem_ready,
  input  logic                i_mem_busy,
  output logic                o_running,
  output logic                o_done,
  output logic                o_timeout,
  output logic                o_err_flag,
  output logic [ERR_W-1:0]    o_err_cnt,
  output logic [PASS_W-1:0]   o_pass_cnt,
  output logic [ADDR_W-1:0]   o_fail_addr,
  output logic [DATA_W-1:0]   o_fail_exp,
  output logic [DATA_W-1:0]   o_fail_got
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur;
  logic              flip;
  logic              stop_q;
  logic [WD_W-1:0]   wd_cnt;

  logic [DATA_W-1:0] pattern;
  logic [ADDR_W:0]   next_addr;
  logic [PASS_W-1:0] pass_inc;
  logic              wrap, last_pass, mismatch, wd_expired, req;

  mem_test_pattern_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_pat (
    .mode    (i_mode),
    .addr    (cur),
    .flip    (flip),
    .pattern (pattern)
  );

  // extra bit catches the step running off the top of the address space
  assign next_addr  = {1'b0, cur} + (ADDR_W+1)'(STRIDE);
  assign wrap       = next_addr[ADDR_W] || (next_addr[ADDR_W-1:0] > i_addr_hi);
  assign pass_inc   = o_pass_cnt + PASS_W'(1);
  assign last_pass  = wrap && (i_passes != '0) && (pass_inc == i_passes);
  assign mismatch   = (i_mem_rd != pattern);
  assign wd_expired = (wd_cnt == '0);
  assign req        = (state == ST_WR_REQ) || (state == ST_RD_REQ);

  assign o_mem_cs   = req;
  assign o_mem_be   = {(DATA_W/8){req}};
  assign o_mem_we   = (state == ST_WR_REQ);
  assign o_mem_wr   = req ? pattern : '0;
  assign o_mem_addr = req ? 32'(cur) : 32'd0;
  assign o_running  = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done     = (state == ST_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      cur         <= '0;
      flip        <= 1'b0;
      stop_q      <= 1'b0;
      wd_cnt      <= '0;
      o_timeout   <= 1'b0;
      o_err_flag  <= 1'b0;
      o_err_cnt   <= '0;
      o_pass_cnt  <= '0;
      o_fail_addr <= '0;
      o_fail_exp  <= '0;
      o_fail_got  <= '0;
    end else begin
      if (o_running && i_stop) stop_q <= 1'b1;
      if (!wd_expired) wd_cnt <= wd_cnt - WD_W'(1);

      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state       <= ST_ARM;
            cur         <= i_addr_lo;
            flip        <= 1'b0;
            stop_q      <= 1'b0;
            o_timeout   <= 1'b0;
            o_err_flag  <= 1'b0;
            o_err_cnt   <= '0;
            o_pass_cnt  <= '0;
            o_fail_addr <= '0;
            o_fail_exp  <= '0;
            o_fail_got  <= '0;
          end
        end
        ST_ARM: begin
          if (!i_mem_busy) begin
            state  <= ST_WR_REQ;
            wd_cnt <= WD_LOAD;
          end
        end
        ST_WR_REQ, ST_RD_REQ: begin
          if (i_mem_busy) begin
            state  <= (state == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
            wd_cnt <= WD_LOAD;
          end else if (wd_expired) begin
            state     <= ST_DONE;
            o_timeout <= 1'b1;
          end
        end
        ST_WR_WAIT: begin
          if (i_mem_ready) begin
            state  <= ST_RD_REQ;
            wd_cnt <= WD_LOAD;
          end else if (wd_expired) begin
            state     <= ST_DONE;
            o_timeout <= 1'b1;
          end
        end
        ST_RD_WAIT: begin
          if (i_mem_ready) begin
            if (mismatch) begin
              o_err_flag <= 1'b1;
              if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + ERR_W'(1);
              if (!o_err_flag) begin
                o_fail_addr <= cur;
                o_fail_exp  <= pattern;
                o_fail_got  <= i_mem_rd;
              end
            end
            if (wrap) begin
              cur        <= i_addr_lo;
              o_pass_cnt <= pass_inc;
              flip       <= ~flip;
            end else begin
              cur <= next_addr[ADDR_W-1:0];
            end
            // stop is honoured only once the write/read pair for this address is complete
            if (last_pass || stop_q || i_stop) begin
              state <= ST_DONE;
            end else begin
              state  <= ST_WR_REQ;
              wd_cnt <= WD_LOAD;
            end
          end else if (wd_expired) begin
            state     <= ST_DONE;
            o_timeout <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
